// File: rtl/tanh_fixed.sv
// Fixed-point tanh coprocessor: odd symmetry, 129-point table over |x| < 8,
// linear interpolation between breakpoints and saturation to +/-1.0 beyond.
module tanh_fixed #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] x_i,
  output logic [DATA_WIDTH-1:0] tanh_o,
  output logic                  done
);

  localparam int DW = DATA_WIDTH;
  localparam int FW = FRAC_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOOKUP,
    S_INTERP,
    S_DONE
  } state_t;

  // T[j] = round(tanh(j/16) * 2^16), built at elaboration from e^(j/8) in Q56
  // integer math; entries that would round to 1.0 are held at 0xFFFF.
  function automatic logic [128:0][16:0] gen_tbl();
    logic [159:0] one;
    logic [159:0] c;
    logic [159:0] term;
    logic [159:0] e;
    logic [159:0] num;
    logic [159:0] den;
    logic [159:0] q;
    logic [128:0][16:0] t;
    one  = 160'd1 << 56;
    c    = '0;
    term = one;
    for (int n = 1; n < 24; n++) begin
      c    = c + term;
      term = term / (160'(n) << 3);
    end
    e = one;
    for (int j = 0; j <= 128; j++) begin
      num  = ((e - one) << 17) + (e + one);
      den  = (e + one) << 1;
      q    = num / den;
      t[j] = (q > 160'hFFFF) ? 17'hFFFF : q[16:0];
      e    = (e * c) >> 56;
    end
    return t;
  endfunction

  localparam logic [128:0][16:0] TBL = gen_tbl();

  state_t state_q, state_d;

  logic          s_q;
  logic          sat_q;
  logic [6:0]    k_q;
  logic [11:0]   f_q;
  logic [16:0]   tk_q;
  logic [16:0]   d_q;
  logic [16:0]   m_q;
  logic [DW-1:0] tanh_q;
  logic          done_q;

  logic [DW-1:0] a_d;
  logic          sat_d;
  logic [7:0]    k0;
  logic [7:0]    k1;
  logic [28:0]   prod;
  logic [16:0]   m_d;
  logic [DW-1:0] mag;

  always_comb begin
    a_d   = x_i[DW-1] ? -x_i : x_i;
    sat_d = |a_d[DW-1:FW+3];
    k0    = {1'b0, k_q};
    k1    = k0 + 8'd1;
    prod  = 29'(d_q) * 29'(f_q) + 29'd2048;
    m_d   = sat_q ? 17'h10000 : tk_q + 17'(prod >> 12);
    mag   = {{(DW-17){1'b0}}, m_q};
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start) state_d = S_LOOKUP;
      S_LOOKUP: state_d = S_INTERP;
      S_INTERP: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      s_q     <= 1'b0;
      sat_q   <= 1'b0;
      k_q     <= '0;
      f_q     <= '0;
      tk_q    <= '0;
      d_q     <= '0;
      m_q     <= '0;
      tanh_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            s_q   <= x_i[DW-1];
            sat_q <= sat_d;
            k_q   <= a_d[FW+2:FW-4];
            f_q   <= a_d[FW-5:0];
          end
        end
        S_LOOKUP: begin
          tk_q <= TBL[k0];
          d_q  <= TBL[k1] - TBL[k0];
        end
        S_INTERP: m_q <= m_d;
        S_DONE: begin
          tanh_q <= s_q ? -mag : mag;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign tanh_o = tanh_q;
  assign done   = done_q;

endmodule

// File: tb/tb_tanh_fixed.sv
// Self-checking bench for tanh_fixed: directed breakpoints and saturation,
// a full sweep against real tanh, random operands and handshake scenarios.
module tb_tanh_fixed;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] x_i;
  logic [31:0] tanh_o;
  logic        done;

  int checks;
  int errors;
  int tbl [0:128];

  tanh_fixed #(.DATA_WIDTH(32), .FRAC_WIDTH(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .x_i    (x_i),
    .tanh_o (tanh_o),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Breakpoint table from real tanh; values that would round to 1.0 sit at 0xFFFF.
  task automatic build_table();
    real v;
    int  t;
    for (int j = 0; j <= 128; j++) begin
      v = $tanh(j / 16.0) * 65536.0;
      t = $rtoi($floor(v + 0.5));
      if (t > 65535) t = 65535;
      tbl[j] = t;
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] x);
    longint xv;
    longint a;
    longint m;
    int     k;
    int     f;
    xv = longint'($signed(x));
    a  = (xv < 0) ? -xv : xv;
    if (a >= 8 * 65536) begin
      m = 65536;
    end else begin
      k = int'(a / 4096);
      f = int'(a % 4096);
      m = tbl[k] + ((tbl[k+1] - tbl[k]) * f + 2048) / 4096;
    end
    return (xv < 0) ? 32'(-m) : 32'(m);
  endfunction

  // One operation: returns first result, cycles to done, and number of done pulses.
  task automatic op(input logic [31:0] x, output logic [31:0] res,
                    output int lat, output int pulses);
    @(negedge clk);
    x_i   = x;
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    x_i    = $urandom;
    lat    = -1;
    pulses = 0;
    res    = tanh_o;
    for (int c = 1; c <= 8; c++) begin
      if (done) begin
        pulses++;
        if (lat < 0) begin
          lat = c;
          res = tanh_o;
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst   = 1'b0;
    start = 1'b1;
    x_i   = 32'h0002_0000;
    repeat (2) @(negedge clk);
    checks++;
    if (tanh_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_tanh: got %h want 00000000", tanh_o);
    end
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL reset_done: got %b want 0", done);
    end
    start = 1'b0;
    rst   = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || tanh_o !== 32'h0) begin
        errors++;
        $display("FAIL idle_quiet: cycle %0d done %b tanh %h want 0/0", c, done, tanh_o);
      end
    end
  endtask

  task automatic test_directed();
    logic [31:0] xs  [8];
    logic [31:0] exp [8];
    logic [31:0] r;
    int          lat;
    int          p;
    xs  = '{32'h0002_0000, 32'hFFFE_0000, 32'h0001_0000, 32'h0000_0000,
            32'h0008_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFF8_0000};
    exp = '{32'h0000_F6CB, 32'hFFFF_0935, 32'h0000_C2F8, 32'h0000_0000,
            32'h0001_0000, 32'h0001_0000, 32'hFFFF_0000, 32'hFFFF_0000};
    for (int i = 0; i < 8; i++) begin
      op(xs[i], r, lat, p);
      checks++;
      if (r !== exp[i]) begin
        errors++;
        $display("FAIL directed_value x=%h: got %h want %h", xs[i], r, exp[i]);
      end
      checks++;
      if (lat != 4 || p != 1) begin
        errors++;
        $display("FAIL directed_timing x=%h: latency %0d pulses %0d want 4/1",
                 xs[i], lat, p);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] x;
    logic [31:0] r;
    logic [31:0] e;
    int          lat;
    int          p;
    for (int i = 0; i < 60; i++) begin
      x = (i % 2 == 0) ? 32'($urandom)
                       : 32'($signed($urandom_range(0, 2 * 589824)) - 589824);
      op(x, r, lat, p);
      e = model(x);
      checks++;
      if (r !== e || lat != 4 || p != 1) begin
        errors++;
        $display("FAIL random x=%h: got %h lat %0d pulses %0d want %h lat 4 pulses 1",
                 x, r, lat, p, e);
      end
    end
  endtask

  task automatic test_sweep();
    localparam int N = 4609;
    logic [31:0] res [N];
    logic [31:0] x;
    logic [31:0] e;
    int          lat;
    int          p;
    real         ideal;
    real         diff;
    for (int i = 0; i < N; i++) begin
      x = 32'(-9 * 65536 + 256 * i);
      op(x, res[i], lat, p);
      e = model(x);
      checks++;
      if (res[i] !== e) begin
        errors++;
        $display("FAIL sweep_model x=%h: got %h want %h", x, res[i], e);
      end
      ideal = $tanh($itor($signed(x)) / 65536.0) * 65536.0;
      diff  = $itor($signed(res[i])) - ideal;
      checks++;
      if (diff > 32.0 || diff < -32.0) begin
        errors++;
        $display("FAIL sweep_accuracy x=%h: got %h ideal %f", x, res[i], ideal);
      end
      if (i > 0) begin
        checks++;
        if ($signed(res[i]) < $signed(res[i-1])) begin
          errors++;
          $display("FAIL sweep_monotonic x=%h: got %h previous %h", x, res[i], res[i-1]);
        end
      end
    end
    for (int i = 0; i < N / 2; i++) begin
      checks++;
      if (res[i] !== -res[N-1-i]) begin
        errors++;
        $display("FAIL sweep_odd i=%0d: got %h want %h", i, res[i], -res[N-1-i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] q[$];
    logic [31:0] e;
    logic        exp_done;
    @(negedge clk);
    for (int c = 0; c <= 24; c++) begin
      if (c > 0) @(negedge clk);
      exp_done = (c >= 4) && (c % 4 == 0);
      checks++;
      if (done !== exp_done) begin
        errors++;
        $display("FAIL b2b_done c=%0d: got %b want %b", c, done, exp_done);
      end
      if (exp_done && q.size() > 0) begin
        e = model(q.pop_front());
        checks++;
        if (tanh_o !== e) begin
          errors++;
          $display("FAIL b2b_value c=%0d: got %h want %h", c, tanh_o, e);
        end
      end
      start = 1'b1;
      x_i   = (c % 2 == 0) ? 32'($urandom)
                           : 32'($signed($urandom_range(0, 1048576)) - 524288);
      if (c % 4 == 0) q.push_back(x_i);
    end
    start = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_mid_start();
    int pulses;
    @(negedge clk);
    x_i   = 32'h0001_0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    x_i   = 32'h0002_0000;
    pulses = 0;
    for (int c = 1; c <= 10; c++) begin
      if (c == 2) start = 1'b1;
      if (c == 3) start = 1'b0;
      if (done) begin
        pulses++;
        checks++;
        if (c != 4 || tanh_o !== 32'h0000_C2F8) begin
          errors++;
          $display("FAIL mid_start_value c=%0d: got %h want 0000c2f8 at c=4", c, tanh_o);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL mid_start_pulses: got %0d want 1", pulses);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] r;
    int          lat;
    int          p;
    int          seen;
    @(negedge clk);
    x_i   = 32'h0002_0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst  = 1'b1;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (done) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen != 0 || tanh_o !== 32'h0) begin
      errors++;
      $display("FAIL abort: pulses %0d tanh %h want 0 and 00000000", seen, tanh_o);
    end
    op(32'h0001_0000, r, lat, p);
    checks++;
    if (r !== 32'h0000_C2F8 || lat != 4 || p != 1) begin
      errors++;
      $display("FAIL abort_recover: got %h lat %0d pulses %0d want 0000c2f8 4 1",
               r, lat, p);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    start  = 1'b0;
    x_i    = '0;
    build_table();
    test_reset();
    test_directed();
    test_random();
    test_sweep();
    test_back_to_back();
    test_mid_start();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
